// File: rtl/mem_access_unit_if.sv
// Data-memory port bundle for mem_access_unit.
// master: the sequencer issuing requests; slave: the data memory answering them.
// Also provides the memory-operation codes shared by the sequencer and its users.

`ifndef MEM_OP_BITS
`define MEM_OP_BITS 2
`endif
`ifndef MEM_OP_NOP
`define MEM_OP_NOP 2'b00
`endif
`ifndef MEM_OP_READ
`define MEM_OP_READ 2'b01
`endif
`ifndef MEM_OP_WRITE
`define MEM_OP_WRITE 2'b10
`endif

interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage sequencer: turns each accepted READ/WRITE into one req/ack
// transaction on the data-memory port, stalls upstream while it is in flight,
// and pulses wb_en for one cycle when a load completes.
// Optional macro MEM_TIMEOUT_EN: abort a request after TIMEOUT_CYCLES cycles
// without ack and pulse bus_error instead of writing back.
//
// state  | meaning
// S_IDLE | waiting for an accepted READ/WRITE; registers address/data/dest
// S_REQ  | mem_req high, address/data held until ack (or timeout)
// S_DONE | one-cycle completion: wb_en for loads, bus_error after a timeout

module mem_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int REG_ADDR_BITS  = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     op_valid,
  input  logic [`MEM_OP_BITS-1:0]  mem_op,
  input  logic                     address_src,
  input  logic [ADDR_WIDTH-1:0]    alu_address,
  input  logic [ADDR_WIDTH-1:0]    imm_address,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic [REG_ADDR_BITS-1:0] dst_reg,
  mem_access_unit_if.master        mem,
  output logic                     stall,
  output logic                     wb_en,
  output logic [REG_ADDR_BITS-1:0] wb_reg,
  output logic [DATA_WIDTH-1:0]    rdata_out,
  output logic                     bus_error
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic                     accept;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic                     we_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [REG_ADDR_BITS-1:0] dst_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     req_int;
  logic                     timeout_hit;
  logic                     timed_out;

  assign accept = op_valid && (mem_op == `MEM_OP_READ || mem_op == `MEM_OP_WRITE);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             timed_out_q;

  // Count REQ cycles without ack; idle at zero so every REQ entry starts clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state != S_REQ) begin
      cnt <= '0;
    end else if (!mem.mem_ack) begin
      cnt <= cnt + 1'b1;
    end
  end

  // An ack on the terminal cycle takes priority over the abort.
  assign timeout_hit = (state == S_REQ) && !mem.mem_ack &&
                       (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Remember why REQ ended so DONE knows whether to report an error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timed_out_q <= 1'b0;
    end else if (state == S_REQ) begin
      timed_out_q <= timeout_hit;
    end else if (state == S_IDLE) begin
      timed_out_q <= 1'b0;
    end
  end

  assign timed_out = timed_out_q;
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE always returns to IDLE without sampling op_valid.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_REQ;
      S_REQ:   if (mem.mem_ack || timeout_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs; stall is gated by reset so it stays low while reset is held.
  always_comb begin
    req_int   = (state == S_REQ);
    stall     = reset && (((state == S_IDLE) && accept) || (state == S_REQ));
    wb_en     = (state == S_DONE) && !we_q && !timed_out;
    bus_error = (state == S_DONE) && timed_out;
  end

  // Capture the request on accept and the load data on ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      dst_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (state == S_IDLE && accept) begin
        addr_q  <= address_src ? imm_address : alu_address;
        we_q    <= (mem_op == `MEM_OP_WRITE);
        wdata_q <= write_data;
        dst_q   <= dst_reg;
      end
      if (state == S_REQ && mem.mem_ack && !we_q) begin
        rdata_q <= mem.mem_rdata;
      end
    end
  end

  assign mem.mem_req   = req_int;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign wb_reg        = dst_q;
  assign rdata_out     = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized bench for mem_access_unit with a transaction-level
// reference model (expected address/data/writeback derived per operation).

module tb_mem_access_unit;

`ifdef MEM_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  mem_op = 2'b00;
  logic        address_src = 1'b0;
  logic [15:0] alu_address = '0;
  logic [15:0] imm_address = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  dst_reg = '0;
  logic        stall, wb_en, bus_error;
  logic [4:0]  wb_reg;
  logic [31:0] rdata_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rdata = '0;

  mem_access_unit_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) mif ();

  mem_access_unit #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .REG_ADDR_BITS(5), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .mem_op(mem_op),
    .address_src(address_src), .alu_address(alu_address),
    .imm_address(imm_address), .write_data(write_data), .dst_reg(dst_reg),
    .mem(mif.master), .stall(stall), .wb_en(wb_en), .wb_reg(wb_reg),
    .rdata_out(rdata_out), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One memory operation from IDLE; ack on the k-th REQ cycle.
  task automatic do_op(input bit is_wr, input bit src, input logic [15:0] alu,
                       input logic [15:0] imm, input logic [31:0] wd,
                       input logic [4:0] dst, input int k, input logic [31:0] rd);
    logic [15:0] exp_addr;
    exp_addr    = src ? imm : alu;
    op_valid    = 1'b1;
    mem_op      = is_wr ? 2'b10 : 2'b01;
    address_src = src;
    alu_address = alu;
    imm_address = imm;
    write_data  = wd;
    dst_reg     = dst;
    mif.mem_ack = 1'b0;
    #1;
    chk("accept_stall", stall, 1);
    chk("accept_req", mif.mem_req, 0);
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      mif.mem_ack   = (i == k);
      mif.mem_rdata = (i == k) ? rd : $urandom;
      #1;
      chk("req_req", mif.mem_req, 1);
      chk("req_stall", stall, 1);
      chk("req_we", mif.mem_we, is_wr);
      chk("req_addr", mif.mem_addr, exp_addr);
      chk("req_wdata", mif.mem_wdata, wd);
      chk("req_wb_en", wb_en, 0);
    end
    if (!is_wr) exp_rdata = rd;
    @(negedge clk);
    mif.mem_ack = 1'b0;
    op_valid    = 1'b0;
    mem_op      = 2'b00;
    #1;
    chk("done_req", mif.mem_req, 0);
    chk("done_stall", stall, 0);
    chk("done_wb_en", wb_en, !is_wr);
    if (!is_wr) chk("done_wb_reg", wb_reg, dst);
    chk("done_rdata", rdata_out, exp_rdata);
    chk("done_bus_error", bus_error, 0);
    @(negedge clk);
    #1;
    chk("idle_wb_en", wb_en, 0);
    chk("idle_req", mif.mem_req, 0);
    chk("idle_rdata", rdata_out, exp_rdata);
  endtask

  initial begin
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;

    // Reset held with a READ presented: everything quiet, no stall.
    op_valid    = 1'b1;
    mem_op      = 2'b01;
    alu_address = 16'h0040;
    dst_reg     = 5'd3;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", mif.mem_req, 0);
    chk("rst_we", mif.mem_we, 0);
    chk("rst_addr", mif.mem_addr, 0);
    chk("rst_wdata", mif.mem_wdata, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_reg", wb_reg, 0);
    chk("rst_rdata", rdata_out, 0);
    chk("rst_bus_error", bus_error, 0);
    chk("rst_stall", stall, 0);
    reset = 1'b1;

    // lw: ack on first REQ cycle.
    do_op(1'b0, 1'b0, 16'h0040, 16'h0000, 32'h0, 5'd3, 1, 32'hDEADBEEF);

    // sa: immediate address, ack after 4 cycles, rdata_out unchanged.
    do_op(1'b1, 1'b1, 16'h7777, 16'h1234, 32'hA5A5A5A5, 5'd9, 4, 32'h12345678);

    // NOP and undefined op codes with stray acks: nothing happens.
    op_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_op      = (i % 2 == 0) ? 2'b00 : 2'b11;
      mif.mem_ack = 1'b1;
      mif.mem_rdata = $urandom;
      #1;
      chk("nop_stall", stall, 0);
      @(negedge clk);
      #1;
      chk("nop_req", mif.mem_req, 0);
      chk("nop_wb_en", wb_en, 0);
      chk("nop_rdata", rdata_out, exp_rdata);
    end
    mif.mem_ack = 1'b0;
    op_valid    = 1'b0;
    do_op(1'b0, 1'b0, 16'h0100, 16'h0, 32'h0, 5'd7, 2, 32'hCAFEF00D);

    // Async reset during the 2nd REQ wait cycle.
    op_valid    = 1'b1;
    mem_op      = 2'b01;
    address_src = 1'b0;
    alu_address = 16'h0200;
    dst_reg     = 5'd12;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_req", mif.mem_req, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", mif.mem_req, 0);
    chk("mid_rst_stall", stall, 0);
    exp_rdata = '0;
    @(negedge clk);
    reset    = 1'b1;
    op_valid = 1'b0;
    mem_op   = 2'b00;
    for (int i = 0; i < 3; i++) begin
      mif.mem_ack = (i == 0);
      @(negedge clk);
      #1;
      chk("post_rst_wb_en", wb_en, 0);
      chk("post_rst_req", mif.mem_req, 0);
      chk("post_rst_rdata", rdata_out, exp_rdata);
    end
    mif.mem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after TO REQ cycles with a bus_error pulse.
    op_valid    = 1'b1;
    mem_op      = 2'b01;
    alu_address = 16'h0300;
    dst_reg     = 5'd4;
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      #1;
      chk("to_req", mif.mem_req, 1);
      chk("to_stall", stall, 1);
    end
    @(negedge clk);
    op_valid = 1'b0;
    mem_op   = 2'b00;
    #1;
    chk("to_done_req", mif.mem_req, 0);
    chk("to_bus_error", bus_error, 1);
    chk("to_wb_en", wb_en, 0);
    chk("to_stall_rel", stall, 0);
    chk("to_rdata", rdata_out, exp_rdata);
    @(negedge clk);
    #1;
    chk("to_idle_bus_error", bus_error, 0);
    // Ack on the terminal cycle wins.
    do_op(1'b0, 1'b0, 16'h0310, 16'h0, 32'h0, 5'd5, TO, 32'h0BADC0DE);
`endif

    // Randomized operations against the transaction model.
    for (int n = 0; n < 24; n++) begin
      do_op(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
            $urandom, 5'($urandom), int'($urandom_range(1, 6)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
